prbs9_tx_mod: RTL and testbench
===============================

// Module: prbs9_tx_mod
// PURPOSE
//  Baseband transmit chain: PRBS9 bit source feeding a x4-oversampled raised-cosine
//  pulse-shaping FIR (polyphase, 24 taps). Emits one 11-bit signed sample per enabled
//  clock. Sits between the test-data source and the DAC/ILA capture in the FPGA design.
// PARAMETERS
//  OS       4        samples per symbol (fixed; polyphase decomposition assumes 4)
//  NSYM     6        filter span in symbols (taps = OS*NSYM = 24)
//  NB_COEF  8        coefficient width, signed S(8,7)
//  NB_OUT   11       output width, signed S(11,7) = NB_COEF+3, never overflows
//  SEED     9'h1FF   PRBS9 reset state
// PORTS
//  clk       in   1   system clock (100 MHz); all logic on rising edge
//  rst       in   1   asynchronous reset, active-low; 0 clears all state immediately
//  enable    in   1   clock enable; 0 freezes every register (outputs hold)
//  bit_out   out  1   current PRBS9 bit (the symbol being loaded)
//  conv_out  out  11  signed shaped sample, two's complement S(11,7)
// BEHAVIOUR
//  Reset (rst=0, async): lfsr=SEED, phase=0, symbol shift reg=6'b0, conv_out=11'd0;
//   bit_out=lfsr[8]=1. On release, nothing moves until enable=1.
//  PRBS9: poly x^9+x^5+1; bit_out=lfsr[8]; advance: lfsr <= {lfsr[7:0], lfsr[8]^lfsr[4]}.
//   Advances only on enabled edges where phase==OS-1 (once per symbol). Period 511
//   symbols, 256 ones/255 zeros; all-zero state unreachable from SEED.
//  Phase counter: 2-bit, increments on each enabled edge, wraps 3->0.
//  Symbol shift reg sr[5:0] (sr[0] newest): on enabled edge with phase==OS-1,
//   sr <= {sr[4:0], bit_out}. Mapping: bit 1 -> +1, bit 0 -> -1 (reset zeros also map -1).
//  Filter: conv_out <= sum_{k=0..5} (sr[k] ? +c[4k+phase] : -c[4k+phase]), evaluated
//   from current sr/phase and registered on each enabled edge (1-cycle latency).
//   Sign-extend coefficients to 11 bits before summing; no saturation needed.
//  Coefficients c[0..23]: raised cosine, rolloff 0.5, T=4 samples, centred at tap 12,
//   quantised round-to-nearest to S(8,7) with c[12]=8'sd127. Nyquist: c[0],c[4],c[8],
//   c[16],c[20]=0, so phase-0 output = +/-127 set only by sr[3]. Symmetric: c[i]=c[24-i].
//  enable low mid-symbol: phase, sr, lfsr, conv_out all hold; resume exactly where left.
//  Reset mid-operation: immediate return to reset values regardless of enable.
// STRUCTURE
//  Package prbs9_tx_pkg: OS, NSYM, NB_COEF, NB_OUT, SEED, coefficient ROM constant
//   array COEF[0:23] as signed [7:0].
//  One sub-module: prbs9_gen (lfsr, bit_out, advance strobe input). Phase counter,
//   symbol register, polyphase MAC (6 adds) and output register in the top.
// TESTING
//  1 Reset: rst=0 -> conv_out=0, bit_out=1 immediately (async); hold rst=1, enable=0
//    for 20 cycles -> no output change.
//  2 PRBS: enable=1 from seed -> bit_out first 9 symbols all 1; then compare against
//    golden x^9+x^5+1 model; sequence repeats after 511 symbols (2044 enabled cycles).
//  3 Nyquist: after >=24 enabled cycles, every phase-0 sample of conv_out = +127
//    (11'h07F) when sr[3]=1, -127 (11'h781) when sr[3]=0.
//  4 Steady all-ones: after first 24 enabled cycles with SEED -> conv_out for phase p =
//    sum c[4k+p] (k=0..5); compare to golden model cycle-exact with 1-cycle latency.
//  5 Enable gating: toggle enable randomly -> output sequence equals the enable=1
//    sequence with enabled-cycle indexing only; no sample skipped or repeated.
//  6 Reset mid-run: assert rst at phase 2 -> all regs to reset values same cycle;
//    after release output replays test 2/4 sequence from the start.

Source files
------------

// File: rtl/prbs9_tx_pkg.sv
// Shared constants, sample type and raised-cosine coefficient ROM for the PRBS9 transmit chain.
package prbs9_tx_pkg;

    localparam int unsigned OS      = 4;
    localparam int unsigned NSYM    = 6;
    localparam int unsigned NTAP    = OS * NSYM;
    localparam int unsigned NB_COEF = 8;
    localparam int unsigned NB_OUT  = NB_COEF + 3;
    localparam int unsigned PH_W    = 2;
    localparam int unsigned LFSR_W  = 9;

    localparam logic [LFSR_W-1:0] SEED = 9'h1FF;

    typedef logic signed [NB_OUT-1:0]  sample_t;
    typedef logic signed [NB_COEF-1:0] coef_t;

    // Raised cosine, rolloff 0.5, 4 samples/symbol, centred on tap 12, S(8,7) rounded.
    localparam coef_t COEF [0:NTAP-1] = '{
        8'sd0,   8'sd1,   8'sd2,   8'sd3,
        8'sd0,  -8'sd7,  -8'sd15, -8'sd16,
        8'sd0,   8'sd33,  8'sd76,  8'sd113,
        8'sd127, 8'sd113, 8'sd76,  8'sd33,
        8'sd0,  -8'sd16, -8'sd15, -8'sd7,
        8'sd0,   8'sd3,   8'sd2,   8'sd1
    };

    // Sign-extend a coefficient to the accumulator/output width.
    function automatic sample_t coef_ext(input coef_t c);
        return NB_OUT'(c);
    endfunction

endpackage

// File: rtl/prbs9_tx_if.sv
// Enable in, PRBS bit and shaped sample out.
interface prbs9_tx_if;
    import prbs9_tx_pkg::*;

    logic    enable;
    logic    bit_out;
    sample_t conv_out;

    modport master (output enable, input bit_out, input conv_out);
    modport slave  (input enable, output bit_out, output conv_out);
endinterface

// File: rtl/prbs9_gen.sv
// PRBS9 (x^9+x^5+1) source; the MSB of the register is the current symbol bit.
module prbs9_gen
    import prbs9_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic bit_out
);

    logic [LFSR_W-1:0] lfsr;

    // Shift in the feedback bit once per symbol.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED;
        end else if (advance) begin
            lfsr <= {lfsr[LFSR_W-2:0], lfsr[8] ^ lfsr[4]};
        end
    end

    assign bit_out = lfsr[LFSR_W-1];

endmodule

// File: rtl/prbs9_tx_mod.sv
// PRBS9 symbols through a x4 polyphase raised-cosine shaper, one sample per enabled clock.
module prbs9_tx_mod
    import prbs9_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    prbs9_tx_if.slave  bus
);

    logic [PH_W-1:0] phase;
    logic [NSYM-1:0] sr;
    logic            advance_c;
    logic            sym_bit;
    sample_t         mac_c;
    sample_t         conv_q;

    // Symbol boundary: last sample phase of the current symbol.
    assign advance_c = bus.enable && (phase == PH_W'(OS - 1));

    prbs9_gen u_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (advance_c),
        .bit_out (sym_bit)
    );

    // Polyphase MAC: each stored symbol adds or subtracts its tap for this phase.
    always_comb begin
        mac_c = '0;
        for (int unsigned k = 0; k < NSYM; k++) begin
            if (sr[k]) begin
                mac_c = mac_c + coef_ext(COEF[OS * k + 32'(phase)]);
            end else begin
                mac_c = mac_c - coef_ext(COEF[OS * k + 32'(phase)]);
            end
        end
    end

    // Phase counter, symbol history and registered output, all frozen when disabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            sr     <= '0;
            conv_q <= '0;
        end else if (bus.enable) begin
            phase  <= phase + PH_W'(1);
            conv_q <= mac_c;
            if (advance_c) begin
                sr <= {sr[NSYM-2:0], sym_bit};
            end
        end
    end

    assign bus.bit_out  = sym_bit;
    assign bus.conv_out = conv_q;

endmodule

// File: tb/tb_prbs9_tx_mod.sv
// Self-checking bench for prbs9_tx_mod against a symbol-level reference model.
module tb_prbs9_tx_mod;

    typedef struct {
        int                 edges;
        bit                 exp_bit;
        logic signed [10:0] exp_conv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int vec_cnt = 0;
    int err_cnt = 0;
    int e_cnt   = 0;

    int coef [0:23];
    bit s    [0:4095];

    prbs9_tx_if bus ();

    prbs9_tx_mod dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: taps from the raised-cosine formula, bits from s[j+9] = s[j] ^ s[j+4].
    task automatic build_model();
        real pi, x, h, v;
        int  t;
        pi = 3.14159265358979;
        for (int i = 0; i < 24; i++) begin
            t = i - 12;
            if (t % 4 == 0) begin
                coef[i] = (t == 0) ? 127 : 0;
            end else begin
                x = real'(t) / 4.0;
                h = ($sin(pi * x) / (pi * x)) * ($cos(pi * x / 2.0) / (1.0 - x * x));
                v = 127.0 * h;
                coef[i] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end
        for (int j = 0; j < 9; j++) s[j] = 1'b1;
        for (int j = 0; j + 9 < 4096; j++) s[j+9] = s[j] ^ s[j+4];
    endtask

    // Output after e enabled edges: the sample computed on edge e-1.
    function automatic int exp_conv(input int e);
        int n, p, m, idx, acc;
        bit b;
        if (e == 0) return 0;
        n   = e - 1;
        p   = n % 4;
        m   = n / 4;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            idx = m - 1 - k;
            b   = (idx >= 0) ? s[idx] : 1'b0;
            acc = b ? acc + coef[4*k+p] : acc - coef[4*k+p];
        end
        return acc;
    endfunction

    function automatic bit exp_bit(input int e);
        return s[e/4];
    endfunction

    task automatic check_now(input string tag);
        logic signed [10:0] ec;
        ec = 11'(exp_conv(e_cnt));
        vec_cnt++;
        if (bus.bit_out !== exp_bit(e_cnt)) begin
            err_cnt++;
            $display("FAIL %s bit_out edges=%0d got %b want %b", tag, e_cnt, bus.bit_out, exp_bit(e_cnt));
        end
        vec_cnt++;
        if (bus.conv_out !== ec) begin
            err_cnt++;
            $display("FAIL %s conv_out edges=%0d got %0d want %0d", tag, e_cnt, bus.conv_out, ec);
        end
    endtask

    task automatic step(input bit en, input string tag);
        bus.enable = en;
        @(posedge clk);
        #1;
        if (en && rst) e_cnt++;
        check_now(tag);
    endtask

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{0,  1'b1, 11'sd0};
        tbl[1]  = '{1,  1'b1, -11'sd127};
        tbl[2]  = '{2,  1'b1, -11'sd127};
        tbl[3]  = '{3,  1'b1, -11'sd126};
        tbl[4]  = '{4,  1'b1, -11'sd127};
        tbl[5]  = '{25, 1'b1, 11'sd127};
        tbl[6]  = '{26, 1'b1, 11'sd127};
        tbl[7]  = '{27, 1'b1, 11'sd126};
        tbl[8]  = '{28, 1'b1, 11'sd127};
        tbl[9]  = '{36, 1'b0, 11'sd127};
        tbl[10] = '{41, 1'b0, 11'sd127};
        tbl[11] = '{53, 1'b0, -11'sd127};

        build_model();
        bus.enable = 1'b0;

        // Async reset before any clock edge.
        #2 rst = 1'b0;
        #1;
        check_now("async_reset");
        @(posedge clk);
        #1;
        check_now("reset_held");
        rst = 1'b1;

        // Released but disabled: nothing may move.
        for (int i = 0; i < 20; i++) step(1'b0, "idle_hold");

        // Table of hand-derived start-up, all-ones and Nyquist points.
        for (int i = 0; i < 12; i++) begin
            while (e_cnt < tbl[i].edges) step(1'b1, "table_run");
            vec_cnt++;
            if (bus.bit_out !== tbl[i].exp_bit) begin
                err_cnt++;
                $display("FAIL table[%0d] bit_out got %b want %b", i, bus.bit_out, tbl[i].exp_bit);
            end
            vec_cnt++;
            if (bus.conv_out !== tbl[i].exp_conv) begin
                err_cnt++;
                $display("FAIL table[%0d] conv_out got %0d want %0d", i, bus.conv_out, tbl[i].exp_conv);
            end
        end

        // Random enable gating across more than one full PRBS period.
        for (int i = 0; i < 3000; i++) step(($urandom % 4) != 0, "rand_gate");
        if (e_cnt < 2100) begin
            for (int i = 0; i < 2100; i++) if (e_cnt < 2100) step(1'b1, "period_fill");
        end

        // Reset at phase 2, checked before the next clock edge.
        for (int i = 0; i < 8; i++) if ((e_cnt % 4) != 2) step(1'b1, "seek_phase2");
        vec_cnt++;
        if ((e_cnt % 4) != 2) begin
            err_cnt++;
            $display("FAIL seek_phase2 phase got %0d want 2", e_cnt % 4);
        end
        bus.enable = 1'b1;
        rst = 1'b0;
        e_cnt = 0;
        #1;
        check_now("mid_reset_async");
        @(posedge clk);
        #1;
        check_now("mid_reset_held");
        rst = 1'b1;

        // Replay from seed, then more gated traffic.
        for (int i = 0; i < 80; i++) step(1'b1, "replay");
        for (int i = 0; i < 300; i++) step(($urandom % 2) != 0, "rand_gate2");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
